// File: rtl/fmrv32im_axi_ledctl.sv
// AXI4-Lite LED controller: NUM_CH channels (off/on/blink/PWM) timed by a shared prescaled tick.
// Optional macro LEDCTL_IRQ_EN adds the IRQ port plus IRQ_STATUS (0x08) and IRQ_MASK (0x0C).
module fmrv32im_axi_ledctl #(
  parameter int NUM_CH     = 4,
  parameter int CLK_HZ     = 48000000,
  parameter int TICK_HZ    = 1000,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [15:0]       S_AXI_AWADDR,
  input  logic              S_AXI_AWVALID,
  output logic              S_AXI_AWREADY,
  input  logic [31:0]       S_AXI_WDATA,
  input  logic [3:0]        S_AXI_WSTRB,
  input  logic              S_AXI_WVALID,
  output logic              S_AXI_WREADY,
  output logic [1:0]        S_AXI_BRESP,
  output logic              S_AXI_BVALID,
  input  logic              S_AXI_BREADY,
  input  logic [15:0]       S_AXI_ARADDR,
  input  logic              S_AXI_ARVALID,
  output logic              S_AXI_ARREADY,
  output logic [31:0]       S_AXI_RDATA,
  output logic [1:0]        S_AXI_RRESP,
  output logic              S_AXI_RVALID,
  input  logic              S_AXI_RREADY,
  output logic [NUM_CH-1:0] LED
`ifdef LEDCTL_IRQ_EN
  ,
  output logic              IRQ
`endif
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW  = $clog2(DIV);
  localparam int CW  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [2:0] {
    SEL_ID, SEL_CTRL, SEL_IRQ_STATUS, SEL_IRQ_MASK,
    SEL_MODE, SEL_PERIOD, SEL_DUTY, SEL_NONE
  } sel_t;

  typedef struct packed {
    sel_t          sel;
    logic [CW-1:0] ch;
  } dec_t;

  function automatic dec_t decode(input logic [15:0] addr);
    dec_t d;
    d.sel = SEL_NONE;
    d.ch  = '0;
    if (addr[15:4] == 12'd0) begin
      case (addr[3:2])
        2'd0: d.sel = SEL_ID;
        2'd1: d.sel = SEL_CTRL;
`ifdef LEDCTL_IRQ_EN
        2'd2: d.sel = SEL_IRQ_STATUS;
        2'd3: d.sel = SEL_IRQ_MASK;
`endif
        default: d.sel = SEL_NONE;
      endcase
    end else if (addr[15:4] <= 12'(NUM_CH)) begin
      d.ch = CW'(addr[15:4] - 12'd1);
      case (addr[3:2])
        2'd0:    d.sel = SEL_MODE;
        2'd1:    d.sel = SEL_PERIOD;
        2'd2:    d.sel = SEL_DUTY;
        default: d.sel = SEL_NONE;
      endcase
    end
    return d;
  endfunction

  function automatic logic [15:0] merge16(input logic [15:0] old, input logic [15:0] wd,
                                          input logic [1:0] strb);
    return {strb[1] ? wd[15:8] : old[15:8], strb[0] ? wd[7:0] : old[7:0]};
  endfunction

  // Handshake: the slave raises AWREADY+WREADY (or ARREADY) for exactly one cycle once
  // the request is presented and no response is pending; the transfer happens in that cycle
  // and BVALID/RVALID then hold with stable payload until the master's BREADY/RREADY.
  logic        wr_ready;
  logic        wr_fire, wr_ok, rd_fire;
  dec_t        wr_d, rd_d;
  logic [31:0] rd_word;

  logic [PW-1:0]     pre;
  logic              tick;
  logic              ctrl_en;
  logic [1:0]        mode   [NUM_CH];
  logic [15:0]       period [NUM_CH];
  logic [15:0]       duty   [NUM_CH];
  logic [15:0]       cnt    [NUM_CH];
  logic [NUM_CH-1:0] blink, wrap, clr, ch_hit, pattern;

`ifdef LEDCTL_IRQ_EN
  logic [NUM_CH-1:0] irq_status, irq_mask, irq_w1c;
`endif

  logic unused_bits;
  assign unused_bits = ^{S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0], S_AXI_WDATA[31:16], S_AXI_WSTRB[3:2]};

  assign S_AXI_AWREADY = wr_ready;
  assign S_AXI_WREADY  = wr_ready;

  always_comb begin
    wr_d    = decode(S_AXI_AWADDR);
    rd_d    = decode(S_AXI_ARADDR);
    wr_fire = wr_ready && S_AXI_AWVALID && S_AXI_WVALID;
    wr_ok   = wr_fire && (wr_d.sel != SEL_NONE);
    rd_fire = S_AXI_ARREADY && S_AXI_ARVALID;
    tick    = (pre == PW'(DIV - 1));
  end

  always_comb begin
    rd_word = '0;
    case (rd_d.sel)
      SEL_ID:     rd_word = {16'h1ED0, 12'd0, 4'(NUM_CH)};
      SEL_CTRL:   rd_word = {31'd0, ctrl_en};
      SEL_MODE:   rd_word = {30'd0, mode[rd_d.ch]};
      SEL_PERIOD: rd_word = {16'd0, period[rd_d.ch]};
      SEL_DUTY:   rd_word = {16'd0, duty[rd_d.ch]};
`ifdef LEDCTL_IRQ_EN
      SEL_IRQ_STATUS: rd_word[NUM_CH-1:0] = irq_status;
      SEL_IRQ_MASK:   rd_word[NUM_CH-1:0] = irq_mask;
`endif
      default: rd_word = '0;
    endcase
  end

  // PERIOD=0 wraps on every tick, same as PERIOD=1.
  always_comb begin
    wrap    = '0;
    clr     = '0;
    ch_hit  = '0;
    pattern = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      ch_hit[i] = wr_ok && (wr_d.ch == CW'(i));
      clr[i]    = ch_hit[i] && ((wr_d.sel == SEL_MODE) || (wr_d.sel == SEL_PERIOD));
      wrap[i]   = tick && ((period[i] == 16'd0) || (cnt[i] >= period[i] - 16'd1));
      case (mode[i])
        2'd0:    pattern[i] = 1'b0;
        2'd1:    pattern[i] = 1'b1;
        2'd2:    pattern[i] = blink[i];
        default: pattern[i] = (cnt[i] < duty[i]);
      endcase
      pattern[i] = pattern[i] & ctrl_en;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ready      <= 1'b0;
      S_AXI_BVALID  <= 1'b0;
      S_AXI_BRESP   <= 2'b00;
      S_AXI_ARREADY <= 1'b0;
      S_AXI_RVALID  <= 1'b0;
      S_AXI_RRESP   <= 2'b00;
      S_AXI_RDATA   <= '0;
    end else begin
      wr_ready <= S_AXI_AWVALID && S_AXI_WVALID && !S_AXI_BVALID && !wr_ready;
      if (wr_fire) begin
        S_AXI_BVALID <= 1'b1;
        S_AXI_BRESP  <= wr_ok ? 2'b00 : 2'b10;
      end else if (S_AXI_BVALID && S_AXI_BREADY) begin
        S_AXI_BVALID <= 1'b0;
      end
      S_AXI_ARREADY <= S_AXI_ARVALID && !S_AXI_RVALID && !S_AXI_ARREADY;
      if (rd_fire) begin
        S_AXI_RVALID <= 1'b1;
        S_AXI_RDATA  <= rd_word;
        S_AXI_RRESP  <= (rd_d.sel == SEL_NONE) ? 2'b10 : 2'b00;
      end else if (S_AXI_RVALID && S_AXI_RREADY) begin
        S_AXI_RVALID <= 1'b0;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pre     <= '0;
      ctrl_en <= 1'b0;
      blink   <= '0;
      LED     <= {NUM_CH{ACTIVE_LOW}};
      for (int i = 0; i < NUM_CH; i++) begin
        mode[i]   <= 2'd0;
        period[i] <= 16'd0;
        duty[i]   <= 16'd0;
        cnt[i]    <= 16'd0;
      end
    end else begin
      pre <= tick ? '0 : pre + PW'(1);
      LED <= pattern ^ {NUM_CH{ACTIVE_LOW}};
      if (wr_ok && (wr_d.sel == SEL_CTRL) && S_AXI_WSTRB[0]) ctrl_en <= S_AXI_WDATA[0];
      for (int i = 0; i < NUM_CH; i++) begin
        if (ch_hit[i] && (wr_d.sel == SEL_MODE) && S_AXI_WSTRB[0]) mode[i] <= S_AXI_WDATA[1:0];
        if (ch_hit[i] && (wr_d.sel == SEL_PERIOD))
          period[i] <= merge16(period[i], S_AXI_WDATA[15:0], S_AXI_WSTRB[1:0]);
        if (ch_hit[i] && (wr_d.sel == SEL_DUTY))
          duty[i] <= merge16(duty[i], S_AXI_WDATA[15:0], S_AXI_WSTRB[1:0]);
        // A MODE/PERIOD write restarts the phase even if a tick lands in the same cycle.
        if (clr[i]) begin
          cnt[i]   <= 16'd0;
          blink[i] <= 1'b0;
        end else if (wrap[i]) begin
          cnt[i]   <= 16'd0;
          blink[i] <= ~blink[i];
        end else if (tick) begin
          cnt[i] <= cnt[i] + 16'd1;
        end
      end
    end
  end

`ifdef LEDCTL_IRQ_EN
  always_comb begin
    irq_w1c = '0;
    if (wr_ok && (wr_d.sel == SEL_IRQ_STATUS) && S_AXI_WSTRB[0]) irq_w1c = S_AXI_WDATA[NUM_CH-1:0];
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      irq_status <= '0;
      irq_mask   <= '0;
      IRQ        <= 1'b0;
    end else begin
      irq_status <= (irq_status & ~irq_w1c) | wrap;
      if (wr_ok && (wr_d.sel == SEL_IRQ_MASK) && S_AXI_WSTRB[0]) irq_mask <= S_AXI_WDATA[NUM_CH-1:0];
      IRQ <= |(irq_status & irq_mask);
    end
  end
`endif

endmodule
